// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store RAM master.
// Provides the RV32 funct3 encodings, the FSM state type, the access-size
// type and small helpers that decode size and alignment from funct3/address.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Loads and stores share the size decode: funct3[1:0] picks the size and
  // every unlisted encoding collapses to a full word.
  function automatic size_t access_size(input logic [2:0] f3);
    case (f3[1:0])
      F3_SB[1:0]: return SZ_B;
      F3_SH[1:0]: return SZ_H;
      default:    return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  // Low address bits after forcing natural alignment for the access size.
  function automatic logic [1:0] align_lo(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter (combinational).
// Selects the byte/half/word lane from a RAM word and sign- or zero-extends it.
//  rdata    in  32  raw RAM read word
//  addr_lo  in  2   byte offset of the load
//  funct3   in  3   RV32 load funct3 (bit 2 = unsigned)
//  result   out 32  extended load result
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (access_size(funct3))
      SZ_B:    result = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    result = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ram_master.sv
// Load/store initiator between the memory stage and a byte-lane data RAM
// with 1-cycle synchronous read latency.
// Optional feature macro: LSU_MISALIGN_EXC_EN (misaligned requests complete
// immediately with rsp_exc_o=1 instead of being force-aligned).
//  clk, rst                 clock, async active-high reset
//  req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//  req_we_i, req_funct3_i   store/load select and RV32 funct3
//  req_addr_i, req_wdata_i  byte address and right-aligned store data
//  req_rd_i                 destination tag, echoed on rsp_rd_o
//  rsp_valid_o              1-cycle completion pulse with rsp_rdata_o/rsp_rd_o/rsp_exc_o
//  ram_wen_o/ram_w_addr_o/ram_w_data_o  RAM write port
//  ram_ren_o/ram_r_addr_o/ram_r_data_i  RAM read port
module lsu_ram_master
  import lsu_pkg::*;
#(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [RD_W-1:0] req_rd_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic [RD_W-1:0] rsp_rd_o,
  output logic            rsp_exc_o,
  output logic [3:0]      ram_wen_o,
  output logic [AW-1:0]   ram_w_addr_o,
  output logic [DW-1:0]   ram_w_data_o,
  output logic            ram_ren_o,
  output logic [AW-1:0]   ram_r_addr_o,
  input  logic [DW-1:0]   ram_r_data_i
);

  state_t          state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      lo_q;
  logic [RD_W-1:0] rd_q;

  size_t           req_size;
  logic [1:0]      req_lo;
  logic [AW-1:0]   req_addr_al;
  logic [3:0]      st_wen;
  logic [DW-1:0]   st_data;
  logic [DW-1:0]   ld_result;
  logic            accept;

  assign accept = req_valid_i & req_ready_o;

  // Request decode: aligned address plus store lane strobes/replicated data.
  always_comb begin
    req_size    = access_size(req_funct3_i);
    req_lo      = align_lo(req_size, req_addr_i[1:0]);
    req_addr_al = {req_addr_i[AW-1:2], req_lo};
    case (req_size)
      SZ_B: begin
        st_wen  = 4'b0001 << req_addr_i[1:0];
        st_data = {4{req_wdata_i[7:0]}};
      end
      SZ_H: begin
        st_wen  = 4'b0011 << {req_addr_i[1], 1'b0};
        st_data = {2{req_wdata_i[15:0]}};
      end
      default: begin
        st_wen  = 4'b1111;
        st_data = req_wdata_i;
      end
    endcase
  end

  lsu_load_fmt u_load_fmt (
    .rdata   (ram_r_data_i),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .result  (ld_result)
  );

`ifdef LSU_MISALIGN_EXC_EN
  logic req_misaligned;
  logic rsp_exc_q;
  assign req_misaligned = is_misaligned(req_size, req_addr_i[1:0]);
  assign rsp_exc_o      = rsp_exc_q;
`else
  assign rsp_exc_o      = 1'b0;
`endif

  // FSM, request registers, RAM strobes and response registers.
  // Strobes are loaded on the accept edge so they are visible during ACCESS
  // and fall back to 0 on every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready_o  <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      lo_q         <= 2'b00;
      rd_q         <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_rd_o     <= '0;
      ram_wen_o    <= 4'b0000;
      ram_w_addr_o <= '0;
      ram_w_data_o <= '0;
      ram_ren_o    <= 1'b0;
      ram_r_addr_o <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      rsp_exc_q    <= 1'b0;
`endif
    end else begin
      rsp_valid_o  <= 1'b0;
      ram_wen_o    <= 4'b0000;
      ram_w_addr_o <= '0;
      ram_w_data_o <= '0;
      ram_ren_o    <= 1'b0;
      ram_r_addr_o <= '0;
      case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (accept) begin
            we_q <= req_we_i;
            f3_q <= req_funct3_i;
            lo_q <= req_lo;
            rd_q <= req_rd_i;
`ifdef LSU_MISALIGN_EXC_EN
            if (req_misaligned) begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= '0;
              rsp_rd_o    <= req_rd_i;
              rsp_exc_q   <= 1'b1;
            end else
`endif
            begin
              state       <= ST_ACCESS;
              req_ready_o <= 1'b0;
              if (req_we_i) begin
                ram_wen_o    <= st_wen;
                ram_w_addr_o <= req_addr_al;
                ram_w_data_o <= st_data;
              end else begin
                ram_ren_o    <= 1'b1;
                ram_r_addr_o <= req_addr_al;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_rd_o    <= rd_q;
`ifdef LSU_MISALIGN_EXC_EN
            rsp_exc_q   <= 1'b0;
`endif
          end else begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // RAM word is valid this cycle; format and register it.
          state       <= ST_IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= ld_result;
          rsp_rd_o    <= rd_q;
`ifdef LSU_MISALIGN_EXC_EN
          rsp_exc_q   <= 1'b0;
`endif
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
